fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage plus IF/ID pipeline register; upstream of decode and the immediate extender.
//  Owns the PC and runs a single-outstanding request to variable-latency instruction memory.
//  Presents id_instr, id_pc and id_pc_plus4 to decode. id_instr[31:7] drives the extender's imm input.
//  Handles decode stalls and EX-stage redirects (taken branch/jump).
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INSTR 32'h0000_0013  value driven on id_instr when id_valid=0 (addi x0,x0,0)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  imem_req      out  1   request strobe; one cycle per request
//  imem_addr     out  32  fetch address, always word aligned ([1:0]=00)
//  imem_rvalid   in   1   response valid; >=1 cycle after imem_req
//  imem_rdata    in   32  instruction word, valid with imem_rvalid
//  id_stall      in   1   hazard unit: hold IF/ID contents
//  ex_redirect   in   1   EX resolved a taken branch/jump
//  ex_target     in   32  redirect PC; bits [1:0] ignored and forced to 00
//  id_valid      out  1   IF/ID holds a live instruction
//  id_instr      out  32  instruction to decode/extender
//  id_pc         out  32  PC of id_instr
//  id_pc_plus4   out  32  id_pc + 4, modulo 2^32
// BEHAVIOUR
//  Reset (async, all regs):
//    pc=RESET_PC, state=IDLE, kill=0, imem_req=0.
//    id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0.
//  FSM states: IDLE, ISSUE, WAIT, HOLD.
//    IDLE: first cycle after reset release; next state ISSUE.
//    ISSUE: imem_req=1, imem_addr=pc; next state WAIT. imem_req=0 in all other states.
//    WAIT, no imem_rvalid: stay in WAIT.
//    WAIT, imem_rvalid & kill: drop data, clear kill, next state ISSUE.
//    WAIT, imem_rvalid & !kill & !id_stall: load IF/ID; pc<=pc+4; next state ISSUE.
//    WAIT, imem_rvalid & !kill & id_stall: capture into hold_instr/hold_pc; next state HOLD.
//    HOLD, !id_stall: load IF/ID from hold regs; pc<=pc+4; next state ISSUE.
//  Redirect (ex_redirect=1, any state, highest priority):
//    pc<={ex_target[31:2],2'b00}; id_valid<=0 next edge, even if id_stall=1.
//    ISSUE: request is already out, so kill<=1 and next state WAIT.
//    WAIT without rvalid: kill<=1.
//    WAIT with rvalid: drop data, kill<=0, next state ISSUE.
//    HOLD: discard hold regs, next state ISSUE.
//    IDLE: pc updated, next state ISSUE.
//  IF/ID update without redirect:
//    id_stall=1: all IF/ID regs hold.
//    id_stall=0 with no instruction delivered this cycle: id_valid<=0 (bubble).
//    On load: id_instr=data, id_pc=pc, id_pc_plus4=pc+4, id_valid=1.
//  id_instr shows NOP_INSTR whenever id_valid=0 (muxed on output, not a separate reg write).
//  Memory protocol and throughput:
//    Max one outstanding request; a new ISSUE only after the response is consumed or dropped.
//    Memory latency L gives at best one instruction per L+1 cycles.
//  Arithmetic: pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
//  Reset asserted mid-request: return to reset state immediately. A late imem_rvalid seen in IDLE/ISSUE is ignored.
// TESTING
//  T1 reset release, L=1, words A,B,C:
//    imem_req at cycle 1 with addr 0x0, then 0x4 and 0x8 every 2 cycles.
//    id_instr=A/B/C with id_pc=0x0/0x4/0x8; id_pc_plus4 correct.
//  T2 id_stall held 3 cycles, asserted when the 0x4 response arrives:
//    FSM in HOLD; IF/ID keeps 0x0; no imem_req.
//    After release, id_pc=0x4 next edge and next request addr=0x8.
//  T3 ex_redirect target 0x103 during WAIT (no rvalid), then rvalid next cycle:
//    Response dropped; next imem_addr=0x100; id_valid=0 meanwhile.
//  T4 ex_redirect and id_stall together while IF/ID valid:
//    id_valid=0 next edge, id_instr=NOP_INSTR; fetch restarts at target.
//  T5 ex_redirect and imem_rvalid in the same WAIT cycle:
//    Data never reaches IF/ID; next request addr=target.
//  T6 RESET_PC=0xFFFF_FFFC:
//    Second fetch addr=0x0, id_pc_plus4=0x0.
//    Reset asserted during WAIT: outputs at reset values, no imem_req until after IDLE.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_if
// Purpose : Instruction-memory, hazard/redirect and IF/ID signals of the fetch stage
// Rev     : 1.0
// ============================================================================
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_rvalid, imem_rdata, id_stall, ex_redirect, ex_target
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_rvalid, imem_rdata, id_stall, ex_redirect, ex_target
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Purpose : PC owner, single-outstanding instruction fetch and IF/ID register
// Rev     : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic         clk,
  input  wire logic         reset,
  fetch_stage_if.master     bus
);

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_req;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_deliver;
  logic        w_load;
  logic [31:0] w_load_instr;
  logic [31:0] w_load_pc;

  assign w_target     = bus.ex_target & c_ALIGN_MASK;
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_deliver    = (r_state == S_WAIT) && bus.imem_rvalid && !r_kill;
  assign w_load       = !bus.ex_redirect && !bus.id_stall && (w_deliver || (r_state == S_HOLD));
  assign w_load_instr = (r_state == S_HOLD) ? r_hold_instr : bus.imem_rdata;
  assign w_load_pc    = (r_state == S_HOLD) ? r_hold_pc    : r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC & c_ALIGN_MASK;
      r_kill       <= 1'b0;
      r_req        <= 1'b0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= 32'd0;
    end else begin
      r_req <= 1'b0;
      if (bus.ex_redirect) begin
        r_pc <= w_target;
        case (r_state)
          // The request left this cycle, so its response must be discarded.
          S_ISSUE: begin
            r_kill  <= 1'b1;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              r_kill  <= 1'b0;
              r_state <= S_ISSUE;
              r_req   <= 1'b1;
            end else begin
              r_kill  <= 1'b1;
            end
          end
          default: begin
            r_state <= S_ISSUE;
            r_req   <= 1'b1;
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ISSUE;
            r_req   <= 1'b1;
          end
          S_ISSUE: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              if (r_kill) begin
                r_kill  <= 1'b0;
                r_state <= S_ISSUE;
                r_req   <= 1'b1;
              end else if (!bus.id_stall) begin
                r_pc    <= w_pc_plus4;
                r_state <= S_ISSUE;
                r_req   <= 1'b1;
              end else begin
                r_hold_instr <= bus.imem_rdata;
                r_hold_pc    <= r_pc;
                r_state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!bus.id_stall) begin
              r_pc    <= w_pc_plus4;
              r_state <= S_ISSUE;
              r_req   <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
    end else if (bus.ex_redirect) begin
      r_id_valid <= 1'b0;
    end else if (!bus.id_stall) begin
      if (w_load) begin
        r_id_valid    <= 1'b1;
        r_id_instr    <= w_load_instr;
        r_id_pc       <= w_load_pc;
        r_id_pc_plus4 <= w_load_pc + 32'd4;
      end else begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.id_valid    = r_id_valid;
  assign bus.id_instr    = r_id_valid ? r_id_instr : NOP_INSTR;
  assign bus.id_pc       = r_id_pc;
  assign bus.id_pc_plus4 = r_id_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Purpose : Directed vector table, wrap/reset sequence and random run against a program-order model
// Rev     : 1.0
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus_a ();
  fetch_stage_if bus_b ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(c_NOP)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(c_NOP)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        st;
    logic        rx;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic st,
                              input logic rx, input logic [31:0] tgt, input logic e_req,
                              input logic [31:0] e_addr, input logic e_v,
                              input logic [31:0] e_instr, input logic [31:0] e_pc);
    vec_t v;
    v.rv = rv; v.rd = rd; v.st = st; v.rx = rx; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic drive_a(input logic rv, input logic [31:0] rd, input logic st,
                         input logic rx, input logic [31:0] tgt);
    bus_a.imem_rvalid = rv;
    bus_a.imem_rdata  = rd;
    bus_a.id_stall    = st;
    bus_a.ex_redirect = rx;
    bus_a.ex_target   = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // random-run model state
  logic [31:0] exp_pc;
  logic        outstanding;
  int          lat_cnt;
  logic [31:0] req_addr;
  logic        p_stall, p_redir;
  logic        s_v;
  logic [31:0] s_instr, s_pc, s_p4;
  int          deliveries;

  initial begin
    logic [31:0] A, B, C, D, E, F, G, H, J, K, W1, W2;
    A = 32'h0010_0093; B = 32'h0020_0113; C = 32'h0030_0193; D = 32'h0040_0213;
    E = 32'h0050_0293; F = 32'hDEAD_0001; G = 32'hDEAD_0002; H = 32'h0060_0313;
    J = 32'hDEAD_0003; K = 32'h0070_0393; W1 = 32'h00C0_0513; W2 = 32'h00D0_0593;

    //             rv rd st rx tgt        req addr        v  instr  pc
    vecs[0]  = mk(0, 0, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0,          1, 32'h0,       0, c_NOP, 0);
    vecs[2]  = mk(1, A, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0,          1, 32'h4,       1, A,     32'h0);
    vecs[4]  = mk(1, B, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0,          1, 32'h8,       1, B,     32'h4);
    vecs[6]  = mk(1, C, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0,          1, 32'hC,       1, C,     32'h8);
    vecs[8]  = mk(1, D, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[9]  = mk(0, 0, 1, 0, 0,          1, 32'h10,      1, D,     32'hC);
    vecs[10] = mk(1, E, 1, 0, 0,          0, 0,           1, D,     32'hC);
    vecs[11] = mk(0, 0, 1, 0, 0,          0, 0,           1, D,     32'hC);
    vecs[12] = mk(0, 0, 0, 0, 0,          0, 0,           1, D,     32'hC);
    vecs[13] = mk(0, 0, 0, 0, 0,          1, 32'h14,      1, E,     32'h10);
    vecs[14] = mk(0, 0, 0, 1, 32'h103,    0, 0,           0, c_NOP, 0);
    vecs[15] = mk(1, F, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[16] = mk(0, 0, 0, 0, 0,          1, 32'h100,     0, c_NOP, 0);
    vecs[17] = mk(1, G, 0, 1, 32'h200,    0, 0,           0, c_NOP, 0);
    vecs[18] = mk(0, 0, 0, 0, 0,          1, 32'h200,     0, c_NOP, 0);
    vecs[19] = mk(1, H, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[20] = mk(0, 0, 1, 1, 32'h300,    1, 32'h204,     1, H,     32'h200);
    vecs[21] = mk(1, J, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[22] = mk(0, 0, 0, 0, 0,          1, 32'h300,     0, c_NOP, 0);
    vecs[23] = mk(1, K, 0, 0, 0,          0, 0,           0, c_NOP, 0);
    vecs[24] = mk(0, 0, 0, 0, 0,          1, 32'h304,     1, K,     32'h300);

    drive_a(0, 0, 0, 0, 0);
    bus_b.imem_rvalid = 0; bus_b.imem_rdata = 0; bus_b.id_stall = 0;
    bus_b.ex_redirect = 0; bus_b.ex_target = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus_a.imem_req}, 0);
    chk("rst_valid", {31'b0, bus_a.id_valid}, 0);
    chk("rst_instr", bus_a.id_instr, c_NOP);
    chk("rst_pc", bus_a.id_pc, 0);
    chk("rst_pc4", bus_a.id_pc_plus4, 0);
    rst_a = 1'b0;

    for (int i = 0; i < 25; i++) begin
      if (i > 0) step();
      drive_a(vecs[i].rv, vecs[i].rd, vecs[i].st, vecs[i].rx, vecs[i].tgt);
      chk($sformatf("v%0d_req", i), {31'b0, bus_a.imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), bus_a.imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, bus_a.id_valid}, {31'b0, vecs[i].e_v});
      chk($sformatf("v%0d_instr", i), bus_a.id_instr, vecs[i].e_instr);
      if (vecs[i].e_v) begin
        chk($sformatf("v%0d_pc", i), bus_a.id_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_pc4", i), bus_a.id_pc_plus4, vecs[i].e_pc + 32'd4);
      end
    end

    // PC wrap and reset during an outstanding request
    step();
    drive_a(0, 0, 0, 0, 0);
    rst_b = 1'b0;
    chk("wrap_idle_req", {31'b0, bus_b.imem_req}, 0);
    step();
    chk("wrap_req1", {31'b0, bus_b.imem_req}, 1);
    chk("wrap_addr1", bus_b.imem_addr, 32'hFFFF_FFFC);
    step();
    bus_b.imem_rvalid = 1; bus_b.imem_rdata = W1;
    step();
    bus_b.imem_rvalid = 0;
    chk("wrap_req2", {31'b0, bus_b.imem_req}, 1);
    chk("wrap_addr2", bus_b.imem_addr, 32'h0);
    chk("wrap_valid", {31'b0, bus_b.id_valid}, 1);
    chk("wrap_instr", bus_b.id_instr, W1);
    chk("wrap_pc", bus_b.id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus_b.id_pc_plus4, 32'h0);
    step();
    rst_b = 1'b1;
    #1;
    chk("midrst_req", {31'b0, bus_b.imem_req}, 0);
    chk("midrst_valid", {31'b0, bus_b.id_valid}, 0);
    chk("midrst_instr", bus_b.id_instr, c_NOP);
    chk("midrst_pc", bus_b.id_pc, 0);
    chk("midrst_pc4", bus_b.id_pc_plus4, 0);
    chk("midrst_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    step();
    rst_b = 1'b0;
    bus_b.imem_rvalid = 1; bus_b.imem_rdata = 32'hBAD0_BAD0;
    chk("late_idle_req", {31'b0, bus_b.imem_req}, 0);
    step();
    bus_b.imem_rvalid = 0;
    chk("late_issue_req", {31'b0, bus_b.imem_req}, 1);
    chk("late_issue_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    chk("late_issue_valid", {31'b0, bus_b.id_valid}, 0);
    step();
    chk("late_wait_req", {31'b0, bus_b.imem_req}, 0);
    bus_b.imem_rvalid = 1; bus_b.imem_rdata = W2;
    step();
    bus_b.imem_rvalid = 0;
    chk("late_load_valid", {31'b0, bus_b.id_valid}, 1);
    chk("late_load_instr", bus_b.id_instr, W2);
    chk("late_load_pc", bus_b.id_pc, 32'hFFFF_FFFC);

    // Random run: delivered stream must follow program order with redirects
    rst_a = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    step();
    rst_a = 1'b0;
    exp_pc = 32'h0; outstanding = 0; lat_cnt = 0; req_addr = 0;
    p_stall = 0; p_redir = 0; deliveries = 0;
    s_v = bus_a.id_valid; s_instr = bus_a.id_instr; s_pc = bus_a.id_pc; s_p4 = bus_a.id_pc_plus4;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      if (p_redir) begin
        chk("rnd_redir_bubble", {31'b0, bus_a.id_valid}, 0);
      end else if (p_stall) begin
        chk("rnd_hold_valid", {31'b0, bus_a.id_valid}, {31'b0, s_v});
        chk("rnd_hold_instr", bus_a.id_instr, s_instr);
        chk("rnd_hold_pc", bus_a.id_pc, s_pc);
        chk("rnd_hold_pc4", bus_a.id_pc_plus4, s_p4);
      end else if (bus_a.id_valid) begin
        chk("rnd_pc", bus_a.id_pc, exp_pc);
        chk("rnd_instr", bus_a.id_instr, memf(exp_pc));
        chk("rnd_pc4", bus_a.id_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (!bus_a.id_valid) chk("rnd_nop", bus_a.id_instr, c_NOP);

      drive_a(0, 0, 0, 0, 0);
      if (bus_a.imem_req) begin
        chk("rnd_single_outstanding", {31'b0, outstanding}, 0);
        chk("rnd_req_addr", bus_a.imem_addr, exp_pc);
      end
      if (outstanding) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus_a.imem_rvalid = 1'b1;
          bus_a.imem_rdata  = memf(req_addr);
          outstanding = 1'b0;
        end
      end
      if (bus_a.imem_req) begin
        outstanding = 1'b1;
        lat_cnt     = int'($urandom_range(1, 4));
        req_addr    = bus_a.imem_addr;
      end
      bus_a.id_stall    = ($urandom_range(0, 3) == 0);
      bus_a.ex_redirect = ($urandom_range(0, 11) == 0);
      bus_a.ex_target   = $urandom;
      p_stall = bus_a.id_stall;
      p_redir = bus_a.ex_redirect;
      if (bus_a.ex_redirect) exp_pc = bus_a.ex_target & 32'hFFFF_FFFC;
      s_v = bus_a.id_valid; s_instr = bus_a.id_instr; s_pc = bus_a.id_pc; s_p4 = bus_a.id_pc_plus4;
    end
    chk("rnd_progress", {31'b0, deliveries > 100}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
